iris_booleanizer: RTL and testbench
===================================

# iris_booleanizer

Upstream stage of the Iris Tsetlin-machine inference datapath. It accepts one raw flower sample as a stream of four unsigned measurement beats and compares each measurement against a runtime-loadable threshold bank. It emits the 9-bit boolean feature vector that the clause-evaluation block consumes. Handshakes are valid/ready on both sides, with one frame in flight at a time.

## Interface
- MEAS_W, 8: width of one measurement beat and of each threshold (unsigned, mm units).
- N_MEAS, 4: beats per frame.
- N_FEAT, 9: output feature bits.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_we  in  1  threshold write strobe.
- cfg_addr  in  4  threshold index; 0..8 valid, 9..15 ignored.
- cfg_wdata  in  MEAS_W  threshold value.
- s_valid  in  1  measurement beat valid.
- s_ready  out  1  block accepts the beat this cycle.
- s_data  in  MEAS_W  measurement: beat0 sepal length, beat1 sepal width, beat2 petal length, beat3 petal width.
- s_last  in  1  marks the final beat of a frame.
- m_valid  out  1  feature vector valid.
- m_ready  in  1  downstream accepts the vector.
- m_features  out  N_FEAT  boolean features.
- m_err  out  1  frame was malformed; m_features is 0.

## Operation
- Feature map:
  - bits[2:0] come from beat0 against th0..th2.
  - bits[4:3] come from beat1 against th3..th4.
  - bits[6:5] come from beat2 against th5..th6.
  - bits[8:7] come from beat3 against th7..th8.
  - Each bit is 1 when meas ≥ th (unsigned compare).
- Reset defaults for th0..th8: 50, 58, 65, 28, 32, 25, 48, 8, 17.
- FSM states: COLLECT, DRAIN, CONVERT, OUT.
- COLLECT:
  - s_ready=1.
  - Each handshake (s_valid&s_ready) stores s_data into slot beat_cnt and increments beat_cnt (0..3).
  - s_last on beat 3: go to CONVERT, err=0.
  - s_last on beat 0..2: go to CONVERT, err=1 (short frame).
  - Beat 3 without s_last: go to DRAIN, err=1.
- DRAIN: s_ready=1. Beats are discarded until an accepted beat carries s_last, then go to CONVERT.
- CONVERT:
  - s_ready=0.
  - Compare the four stored beats against the current thresholds.
  - Register the result, or 0 when err=1, into m_features, together with m_err.
  - Go to OUT.
- OUT: m_valid=1, outputs held stable. On m_ready, go to COLLECT and clear beat_cnt.
- Config writes:
  - Accepted in any state.
  - A write landing on the same edge that ends CONVERT is not seen by that frame; the compare uses the pre-write value.
  - Writes to addr 9..15 have no effect.
- Reset mid-frame: the partial frame is lost and thresholds revert to their defaults.

## Timing
- Reset values:
  - s_ready=1 (state COLLECT).
  - m_valid=0, m_features=0, m_err=0.
  - beat_cnt=0, thresholds at defaults.
- Latency: with the last beat accepted at edge E, m_valid rises after edge E+1, i.e. 2 cycles after the last-beat handshake cycle.
- s_ready:
  - Deasserted from edge E until the edge on which m_valid&m_ready is sampled.
  - Reasserted in the following cycle.
- Minimum frame period with m_ready tied high is 6 cycles: 4 beats, CONVERT, OUT.
- m_valid must not drop, and m_features/m_err must not change, while m_ready=0.
- s_valid gaps are allowed in COLLECT and DRAIN; beat_cnt holds during gaps.

## Structure
- Package iris_pkg holds:
  - MEAS_W, N_MEAS, N_FEAT.
  - Per-feature measurement-index and threshold-index map constants.
  - TH_DEFAULT array.
  - The FSM state enum: COLLECT, DRAIN, CONVERT, OUT.
- One sub-module, iris_threshold_bank:
  - Nine MEAS_W registers with the reset defaults and the cfg write port.
  - Nine comparators taking four measurements and producing the N_FEAT vector combinationally.
- The top level holds the FSM, beat buffer, beat_cnt and output registers.

## Test plan
- Default thresholds, frame 51,35,14,2 (s_last on beat 3), m_ready=1 -> m_features=9'h019, m_err=0, m_valid 2 cycles after the last handshake.
- Default thresholds, frame 63,33,60,25 -> 9'h1FB. Boundary frame 50,28,25,8 -> 9'h0A9 (equality counts as 1).
- Write th0=52 with cfg_we, then frame 51,35,14,2 -> 9'h018. Write issued on the CONVERT-ending edge -> still 9'h019.
- Short frame 51,35 with s_last on beat 1 -> m_err=1, m_features=0. The next well-formed frame is correct.
- Six beats, s_last on beat 5 -> one m_err=1 output only after beat 5, with s_ready=1 during beats 4-5.
- Hold m_ready=0 for 10 cycles: outputs stable, s_ready=0. Assert rst_n=0 mid-frame after 2 beats: all outputs go to reset values immediately, and the next frame is not polluted.

Source files
------------

// File: rtl/iris_booleanizer_pkg.sv
// Shared widths, feature map and defaults for the Iris booleanizer.
package iris_pkg;

    localparam int MEAS_W = 8;
    localparam int N_MEAS = 4;
    localparam int N_FEAT = 9;

    // Feature f compares measurement FEAT_MEAS_IDX[f] against threshold FEAT_TH_IDX[f].
    localparam int FEAT_MEAS_IDX [N_FEAT] = '{0, 0, 0, 1, 1, 2, 2, 3, 3};
    localparam int FEAT_TH_IDX   [N_FEAT] = '{0, 1, 2, 3, 4, 5, 6, 7, 8};

    // Power-on threshold bank, in mm.
    localparam logic [MEAS_W-1:0] TH_DEFAULT [N_FEAT] =
        '{8'd50, 8'd58, 8'd65, 8'd28, 8'd32, 8'd25, 8'd48, 8'd8, 8'd17};

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DRAIN   = 2'd1,
        CONVERT = 2'd2,
        OUT     = 2'd3
    } state_t;

endpackage

// File: rtl/iris_booleanizer_if.sv
// Measurement-in / feature-out stream bundle.
interface iris_booleanizer_if;
    import iris_pkg::*;

    logic              s_valid;
    logic              s_ready;
    logic [MEAS_W-1:0] s_data;
    logic              s_last;
    logic              m_valid;
    logic              m_ready;
    logic [N_FEAT-1:0] m_features;
    logic              m_err;

    // Booleanizer side.
    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_features, m_err
    );

    // Sample source / feature sink side.
    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_features, m_err
    );

endinterface

// File: rtl/iris_booleanizer_threshold_bank.sv
// Runtime-loadable threshold registers and the nine unsigned comparators.
module iris_threshold_bank
    import iris_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           cfg_we_i,
    input  logic [3:0]                     cfg_addr_i,
    input  logic [MEAS_W-1:0]              cfg_wdata_i,
    input  logic [N_MEAS-1:0][MEAS_W-1:0]  meas_i,
    output logic [N_FEAT-1:0]              features_o
);

    logic [MEAS_W-1:0] th_w [N_FEAT];

    for (genvar t = 0; t < N_FEAT; t++) begin : g_th
        logic [MEAS_W-1:0] th_q;

        // Threshold t: default on reset, overwritten by a matching cfg write.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                th_q <= TH_DEFAULT[t];
            end else if (cfg_we_i && (cfg_addr_i == 4'(t))) begin
                th_q <= cfg_wdata_i;
            end
        end

        assign th_w[t] = th_q;
    end

    // Comparators read the registered thresholds, so a write on the capture
    // edge is only visible to the following frame.
    for (genvar f = 0; f < N_FEAT; f++) begin : g_cmp
        assign features_o[f] = (meas_i[FEAT_MEAS_IDX[f]] >= th_w[FEAT_TH_IDX[f]]);
    end

endmodule

// File: rtl/iris_booleanizer.sv
// Iris booleanizer: collects a 4-beat sample, thresholds it into 9 feature bits.
//
// state   | meaning
// COLLECT | accepting beats 0..3 into the beat buffer
// DRAIN   | overlong frame, discarding beats until s_last
// CONVERT | comparing buffered beats, registering the result
// OUT     | presenting m_features/m_err until m_ready
module iris_booleanizer
    import iris_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [3:0]         cfg_addr,
    input  logic [MEAS_W-1:0]  cfg_wdata,
    iris_booleanizer_if.slave  bus
);

    state_t                         state_q, state_d;
    logic [1:0]                     beat_cnt_q, beat_cnt_d;
    logic                           err_q, err_d;
    logic [N_MEAS-1:0][MEAS_W-1:0]  beat_buf_q;
    logic [N_FEAT-1:0]              m_features_q;
    logic                           m_err_q;
    logic [N_FEAT-1:0]              feat_w;
    logic                           s_ready_w;
    logic                           s_hs_w;

    assign s_ready_w = (state_q == COLLECT) || (state_q == DRAIN);
    assign s_hs_w    = bus.s_valid && s_ready_w;

    iris_threshold_bank u_bank (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we_i    (cfg_we),
        .cfg_addr_i  (cfg_addr),
        .cfg_wdata_i (cfg_wdata),
        .meas_i      (beat_buf_q),
        .features_o  (feat_w)
    );

    // Frame sequencing: beat counting, framing-error detection, output handshake.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        err_d      = err_q;
        case (state_q)
            COLLECT: begin
                if (s_hs_w) begin
                    beat_cnt_d = beat_cnt_q + 2'd1;
                    if (bus.s_last) begin
                        state_d = CONVERT;
                        err_d   = (beat_cnt_q != 2'd3);
                    end else if (beat_cnt_q == 2'd3) begin
                        state_d = DRAIN;
                        err_d   = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (s_hs_w && bus.s_last) begin
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                state_d = OUT;
            end
            OUT: begin
                if (bus.m_ready) begin
                    state_d    = COLLECT;
                    beat_cnt_d = 2'd0;
                end
            end
            default: begin
                state_d    = COLLECT;
                beat_cnt_d = 2'd0;
            end
        endcase
    end

    // FSM and framing registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= COLLECT;
            beat_cnt_q <= 2'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
        end
    end

    // Beat buffer: only beats accepted in COLLECT are kept; DRAIN beats are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_buf_q <= '0;
        end else if ((state_q == COLLECT) && s_hs_w) begin
            beat_buf_q[beat_cnt_q] <= bus.s_data;
        end
    end

    // Output capture on the single CONVERT cycle; held through OUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_features_q <= '0;
            m_err_q      <= 1'b0;
        end else if (state_q == CONVERT) begin
            m_features_q <= err_q ? '0 : feat_w;
            m_err_q      <= err_q;
        end
    end

    assign bus.s_ready    = s_ready_w;
    assign bus.m_valid    = (state_q == OUT);
    assign bus.m_features = m_features_q;
    assign bus.m_err      = m_err_q;

endmodule

// File: tb/tb_iris_booleanizer.sv
// Self-checking bench for iris_booleanizer: directed cases plus randomized frames
// against a threshold-table reference model.
module tb_iris_booleanizer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_we = 1'b0;
    logic [3:0] cfg_addr = '0;
    logic [7:0] cfg_wdata = '0;

    iris_booleanizer_if bus();

    iris_booleanizer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int th_m [9];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        th_m = '{50, 58, 65, 28, 32, 25, 48, 8, 17};
    endfunction

    // Feature f uses beat 0 for f<3, otherwise beat (f-1)/2.
    function automatic logic [8:0] model_features(input int m[4]);
        logic [8:0] r;
        r = '0;
        for (int f = 0; f < 9; f++) begin
            int b;
            b = (f < 3) ? 0 : (f - 1) / 2;
            r[f] = (m[b] >= th_m[f]);
        end
        return r;
    endfunction

    task automatic cfg_write(input logic [3:0] a, input logic [7:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(negedge clk);
        cfg_we = 1'b0;
        if (a < 9) th_m[a] = d;
    endtask

    // Drives beats at negedges; returns at the negedge after the last handshake.
    task automatic send_frame(input int beats[$], input int gap_max);
        for (int i = 0; i < beats.size(); i++) begin
            int g;
            g = (i == 0) ? 0 : $urandom_range(0, gap_max);
            repeat (g) @(negedge clk);
            bus.s_valid = 1'b1;
            bus.s_data  = beats[i][7:0];
            bus.s_last  = (i == beats.size() - 1);
            check_eq("beat_s_ready", bus.s_ready, 1);
            check_eq("beat_m_valid", bus.m_valid, 0);
            @(negedge clk);
            bus.s_valid = 1'b0;
            bus.s_last  = 1'b0;
        end
    endtask

    // Starts one negedge after the last handshake; optionally issues a cfg write
    // timed onto the edge that ends CONVERT.
    task automatic recv(input string tag, input logic [8:0] exp_f, input logic exp_e,
                        input int hold, input bit cw, input logic [3:0] ca, input logic [7:0] cd);
        int lat;
        check_eq({tag, "_cv_m_valid"}, bus.m_valid, 0);
        check_eq({tag, "_cv_s_ready"}, bus.s_ready, 0);
        if (cw) begin
            cfg_we = 1'b1; cfg_addr = ca; cfg_wdata = cd;
        end
        lat = 1;
        do begin
            @(negedge clk);
            lat++;
            cfg_we = 1'b0;
        end while (!bus.m_valid && lat < 20);
        if (cw && ca < 9) th_m[ca] = cd;
        check_eq({tag, "_m_valid"}, bus.m_valid, 1);
        check_eq({tag, "_latency"}, lat, 2);
        check_eq({tag, "_features"}, bus.m_features, exp_f);
        check_eq({tag, "_err"}, bus.m_err, exp_e);
        check_eq({tag, "_s_ready_out"}, bus.s_ready, 0);
        repeat (hold) begin
            @(negedge clk);
            check_eq({tag, "_hold_valid"}, bus.m_valid, 1);
            check_eq({tag, "_hold_feat"}, bus.m_features, exp_f);
            check_eq({tag, "_hold_err"}, bus.m_err, exp_e);
            check_eq({tag, "_hold_s_ready"}, bus.s_ready, 0);
        end
        bus.m_ready = 1'b1;
        @(negedge clk);
        bus.m_ready = 1'b0;
        check_eq({tag, "_post_valid"}, bus.m_valid, 0);
        check_eq({tag, "_post_s_ready"}, bus.s_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int q[$];
        int m[4];
        logic [8:0] ef;
        model_reset();
        bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0; bus.m_ready = 1'b0;

        repeat (2) @(negedge clk);
        check_eq("rst_s_ready", bus.s_ready, 1);
        check_eq("rst_m_valid", bus.m_valid, 0);
        check_eq("rst_features", bus.m_features, 0);
        check_eq("rst_err", bus.m_err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        q = '{51, 35, 14, 2};   send_frame(q, 0); recv("basic", 9'h019, 0, 0, 0, 0, 0);
        q = '{63, 33, 60, 25};  send_frame(q, 2); recv("high",  9'h1FB, 0, 0, 0, 0, 0);
        q = '{50, 28, 25, 8};   send_frame(q, 0); recv("edge",  9'h0A9, 0, 0, 0, 0, 0);

        cfg_write(4'd0, 8'd52);
        q = '{51, 35, 14, 2};   send_frame(q, 0); recv("th0w",  9'h018, 0, 0, 0, 0, 0);
        cfg_write(4'd12, 8'd0);
        q = '{51, 35, 14, 2};   send_frame(q, 0); recv("badaddr", 9'h018, 0, 0, 0, 0, 0);
        cfg_write(4'd0, 8'd50);
        q = '{51, 35, 14, 2};   send_frame(q, 0); recv("cvwrite", 9'h019, 0, 0, 1, 4'd0, 8'd52);
        q = '{51, 35, 14, 2};   send_frame(q, 0); recv("aftercv", 9'h018, 0, 0, 0, 0, 0);
        cfg_write(4'd0, 8'd50);

        q = '{51, 35};                  send_frame(q, 1); recv("short", 9'h000, 1, 0, 0, 0, 0);
        q = '{63, 33, 60, 25};          send_frame(q, 0); recv("after_short", 9'h1FB, 0, 0, 0, 0, 0);
        q = '{1, 2, 3, 4, 5, 6};        send_frame(q, 1); recv("long", 9'h000, 1, 0, 0, 0, 0);
        q = '{50, 28, 25, 8};           send_frame(q, 0); recv("hold", 9'h0A9, 0, 10, 0, 0, 0);

        // Reset mid-frame after two beats, with a non-default threshold loaded.
        cfg_write(4'd0, 8'd52);
        bus.s_valid = 1'b1; bus.s_data = 8'd99;
        @(negedge clk);
        bus.s_data = 8'd99;
        @(negedge clk);
        bus.s_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_s_ready", bus.s_ready, 1);
        check_eq("midrst_m_valid", bus.m_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        q = '{51, 35, 14, 2};   send_frame(q, 0); recv("post_rst", 9'h019, 0, 0, 0, 0, 0);

        // Reset while a result is being presented.
        q = '{63, 33, 60, 25};  send_frame(q, 0);
        @(negedge clk);
        check_eq("outrst_pre_valid", bus.m_valid, 1);
        rst_n = 1'b0;
        #1;
        check_eq("outrst_m_valid", bus.m_valid, 0);
        check_eq("outrst_features", bus.m_features, 0);
        check_eq("outrst_err", bus.m_err, 0);
        check_eq("outrst_s_ready", bus.s_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);

        for (int it = 0; it < 30; it++) begin
            int len;
            bit cw;
            logic [3:0] ca;
            logic [7:0] cd;
            if ($urandom_range(0, 2) == 0) cfg_write(4'($urandom_range(0, 15)), 8'($urandom_range(0, 80)));
            len = ($urandom_range(0, 9) < 6) ? 4 : $urandom_range(1, 7);
            q.delete();
            for (int b = 0; b < len; b++) q.push_back($urandom_range(0, 80));
            for (int b = 0; b < 4; b++) m[b] = (b < len) ? q[b] : 0;
            ef = (len == 4) ? model_features(m) : 9'h000;
            cw = ($urandom_range(0, 3) == 0);
            ca = 4'($urandom_range(0, 15));
            cd = 8'($urandom_range(0, 80));
            send_frame(q, 2);
            recv("rand", ef, (len != 4), $urandom_range(0, 3), cw, ca, cd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
